s_pdif_transmitter: RTL
=======================

S_PDIF_TRANSMITTER -- requirements
Module: S_PDIF_Transmitter

Interface
REQ-001 SHALL have ports: Clk  input  1  system clock, 48 MHz; all logic on rising edge.
REQ-002 SHALL have ports: nReset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Tick  input  1  one-Clk strobe at 128*Fs; one strobe per biphase half-cell; strobes at least 2 Clk apart.
REQ-004 SHALL have ports: Left  input  24  left sample, two's complement.
REQ-005 SHALL have ports: Right  input  24  right sample, two's complement.
REQ-006 SHALL have ports: Valid  input  1  Left/Right pair is offered.
REQ-007 SHALL have ports: Ready  output  1  holding register is empty; pair accepted on a Clk edge with Valid&Ready.
REQ-008 SHALL have ports: ChannelStatus  input  32  channel-status bits 0..31; bits 32..191 are 0.
REQ-009 SHALL have ports: Underrun  output  1  one-Clk pulse when a frame starts with no sample held.
REQ-010 SHALL have ports: S_PDIF_Out  output  1  registered biphase-mark line output.

Function
REQ-011 SHALL use 2 subframes per frame (left, then right) and 32 slots per subframe:
  - slots 0-3: preamble;
  - slots 4-27: audio, LSB first;
  - slot 28: V;
  - slot 29: U = 0;
  - slot 30: C;
  - slot 31: P.
REQ-012 SHALL split each slot into 2 half-cells, giving 128 half-cells per frame; each Tick advances exactly one half-cell.
REQ-013 SHALL encode slots 4-31 as biphase mark: the line toggles at the start of every slot, and toggles again mid-slot when the bit is 1.
REQ-014 SHALL drive the preamble as 8 half-cell levels, given for a previous line level of 0 and inverted bitwise when the previous level is 1:
  - B = 11101000 (left subframe of frame 0);
  - M = 11100010 (left subframe of other frames);
  - W = 11100100 (right subframe).
REQ-015 SHALL set P so that slots 4-31 of each subframe contain an even number of ones.
REQ-016 SHALL keep a frame counter 0..191 that increments after each right subframe and wraps from 191 to 0.
REQ-017 SHALL set C in both subframes to ChannelStatus[frame] when frame < 32, otherwise 0.
REQ-018 SHALL update S_PDIF_Out on the Clk edge following a Tick (latency 1 Clk), and hold it between Ticks.
REQ-019 SHALL provide a single-entry holding register: Ready=1 when it is empty; Valid&Ready loads it and clears Ready on the next cycle.
REQ-020 SHALL, on the Tick that starts half-cell 0 of a frame, transfer a full holding register into the frame shift register, empty the holding register, and assert Ready on the next cycle.
REQ-021 SHALL, on that same Tick with an empty holding register, transmit audio = 0 and V = 1 in both subframes and pulse Underrun for 1 Clk; otherwise V = 0.
REQ-022 SHALL evaluate the frame-start transfer against the holding-register state before the edge; a pair accepted on the same edge is held for the next frame.
REQ-023 SHALL ignore Valid while Ready=0, with no overwrite of the held pair.
REQ-024 SHALL ignore changes to ChannelStatus between frames, sampling it per frame at frame start.

Reset
REQ-025 SHALL, while nReset=0, asynchronously force:
  - S_PDIF_Out=0, Ready=1, Underrun=0;
  - holding register empty;
  - frame counter=0, slot=0, half-cell=0.
REQ-026 SHALL begin frame 0 (preamble B, previous level 0) on the first Tick after nReset rises.
REQ-027 SHALL abandon any partial frame when reset is asserted mid-frame; no output toggles and no Underrun occur while in reset.

Verification
REQ-028 Reset: hold nReset=0 with Ticks running -> S_PDIF_Out=0, Ready=1, Underrun=0 throughout.
REQ-029 Data: Left=24'h000001, Right=24'h800000, Valid before frame 0 -> decoded left audio 000001, right 800000, V=0, parity even, preambles B then W.
REQ-030 Underrun: no Valid before a frame start -> Underrun pulses once; both subframes carry audio 0, V=1, correct P.
REQ-031 Block: ChannelStatus=32'hA5A5_0004, 193 frames supplied -> preamble B on frames 0 and 192, M on all others; C bits match ChannelStatus for frames 0-31 and are 0 for frames 32-191.
REQ-032 Polarity: decode frames where the line level is 1 before a preamble -> the preamble is bitwise inverted, and every slot boundary shows a transition.
REQ-033 Mid-frame reset: pulse nReset low at slot 15 of the right subframe -> S_PDIF_Out=0 immediately; after release, the next frame starts with preamble B and frame counter 0.

Source files
------------

// File: rtl/s_pdif_transmitter.sv
// S/PDIF (IEC 60958) biphase-mark transmitter: two 24-bit subframes per frame,
// 192-frame channel-status block, single-entry sample holding register.
module s_pdif_transmitter (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Tick,
    input  logic [23:0] Left,
    input  logic [23:0] Right,
    input  logic        Valid,
    output logic        Ready,
    input  logic [31:0] ChannelStatus,
    output logic        Underrun,
    output logic        S_PDIF_Out
);

    // Preamble half-cell levels, first half-cell in the MSB, for a previous level of 0.
    localparam logic [7:0] PRE_B = 8'b1110_1000;
    localparam logic [7:0] PRE_M = 8'b1110_0010;
    localparam logic [7:0] PRE_W = 8'b1110_0100;

    logic [6:0]  pos_q, pos_d;          // next half-cell of the frame to emit
    logic [7:0]  frame_q, frame_d;
    logic        hold_full_q, hold_full_d;
    logic [23:0] hold_left_q, hold_left_d;
    logic [23:0] hold_right_q, hold_right_d;
    logic [23:0] cur_left_q, cur_left_d;
    logic [23:0] cur_right_q, cur_right_d;
    logic        cur_v_q, cur_v_d;
    logic        cur_c_q, cur_c_d;
    logic        pol_q, pol_d;
    logic        line_q, line_d;
    logic        underrun_q, underrun_d;

    logic        sub;
    logic [5:0]  sub_pos;
    logic [4:0]  slot;
    logic        phase;
    logic [23:0] audio;
    logic        parity;
    logic [31:0] sub_word;
    logic        prev_level;
    logic [7:0]  pre_pat;

    always_comb begin
        sub        = pos_q[6];
        sub_pos    = pos_q[5:0];
        slot       = pos_q[5:1];
        phase      = pos_q[0];
        audio      = sub ? cur_right_q : cur_left_q;
        parity     = ^{cur_c_q, cur_v_q, audio};
        // Indexed directly by slot number; slots 0-3 are never read from here.
        sub_word   = {parity, cur_c_q, 1'b0, cur_v_q, audio, 4'b0000};
        prev_level = (sub_pos == 6'd0) ? line_q : pol_q;
        pre_pat    = sub ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
    end

    always_comb begin
        pos_d        = pos_q;
        frame_d      = frame_q;
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        cur_left_d   = cur_left_q;
        cur_right_d  = cur_right_q;
        cur_v_d      = cur_v_q;
        cur_c_d      = cur_c_q;
        pol_d        = pol_q;
        line_d       = line_q;
        underrun_d   = 1'b0;

        if (Tick) begin
            pos_d = pos_q + 7'd1;
            if (sub_pos == 6'd0) begin
                pol_d = line_q;
            end
            if (slot[4:2] == 3'd0) begin
                line_d = pre_pat[~sub_pos[2:0]] ^ prev_level;
            end else if (!phase) begin
                line_d = ~line_q;
            end else begin
                line_d = line_q ^ sub_word[slot];
            end
            if (pos_q == 7'd127) begin
                frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
            end
            if (pos_q == 7'd0) begin
                // Decision uses the holding register as it was before this edge.
                if (hold_full_q) begin
                    cur_left_d  = hold_left_q;
                    cur_right_d = hold_right_q;
                    cur_v_d     = 1'b0;
                    hold_full_d = 1'b0;
                end else begin
                    cur_left_d  = 24'd0;
                    cur_right_d = 24'd0;
                    cur_v_d     = 1'b1;
                    underrun_d  = 1'b1;
                end
                cur_c_d = (frame_q[7:5] == 3'd0) ? ChannelStatus[frame_q[4:0]] : 1'b0;
            end
        end

        if (Valid && !hold_full_q) begin
            hold_full_d  = 1'b1;
            hold_left_d  = Left;
            hold_right_d = Right;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pos_q        <= 7'd0;
            frame_q      <= 8'd0;
            hold_full_q  <= 1'b0;
            hold_left_q  <= 24'd0;
            hold_right_q <= 24'd0;
            cur_left_q   <= 24'd0;
            cur_right_q  <= 24'd0;
            cur_v_q      <= 1'b0;
            cur_c_q      <= 1'b0;
            pol_q        <= 1'b0;
            line_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            frame_q      <= frame_d;
            hold_full_q  <= hold_full_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            cur_left_q   <= cur_left_d;
            cur_right_q  <= cur_right_d;
            cur_v_q      <= cur_v_d;
            cur_c_q      <= cur_c_d;
            pol_q        <= pol_d;
            line_q       <= line_d;
            underrun_q   <= underrun_d;
        end
    end

    assign Ready      = ~hold_full_q;
    assign Underrun   = underrun_q;
    assign S_PDIF_Out = line_q;

endmodule
